// File: rtl/miriscv_ram_arbiter.sv
// RAM arbiter and boot sequencer for loader, fetch and LSU ports.
// Define ARB_RR_EN for instr/data round-robin; default is data > instr.
module miriscv_ram_arbiter #(
  parameter int RAM_SIZE  = 512,
  parameter int BOOT_HOLD = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        instr_req_i,
  input  logic [31:0]                 instr_addr_i,
  output logic                        instr_gnt_o,
  output logic                        instr_rvalid_o,
  output logic [31:0]                 instr_rdata_o,
  input  logic                        data_req_i,
  input  logic                        data_we_i,
  input  logic [3:0]                  data_be_i,
  input  logic [31:0]                 data_addr_i,
  input  logic [31:0]                 data_wdata_i,
  output logic                        data_gnt_o,
  output logic                        data_rvalid_o,
  output logic [31:0]                 data_rdata_o,
  input  logic                        ld_req_i,
  input  logic [31:0]                 ld_addr_i,
  input  logic [31:0]                 ld_wdata_i,
  output logic                        ld_gnt_o,
  input  logic                        ld_done_i,
  output logic                        core_rst_n_o,
  output logic                        ram_req_o,
  output logic                        ram_we_o,
  output logic [3:0]                  ram_be_o,
  output logic [$clog2(RAM_SIZE)-1:0] ram_addr_o,
  output logic [31:0]                 ram_wdata_o,
  input  logic [31:0]                 ram_rdata_i
);

  localparam int ADDR_W = $clog2(RAM_SIZE);

  typedef enum logic [1:0] {
    BOOT,
    HOLD,
    RUN
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BOOT;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      BOOT: begin
        if (ld_done_i) begin
          state_d = HOLD;
          cnt_d   = 4'(BOOT_HOLD);
        end
      end
      HOLD: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  assign core_rst_n_o = (state_q == RUN);

  logic core_en;
  logic pick_data;

  // Loader always wins; core ports only once released
  assign core_en = core_rst_n_o & ~ld_req_i;

`ifdef ARB_RR_EN
  logic rr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= 1'b1;
    end else if (instr_gnt_o) begin
      rr_q <= 1'b0;
    end else if (data_gnt_o) begin
      rr_q <= 1'b1;
    end
  end

  assign pick_data = data_req_i & (~instr_req_i | ~rr_q);
`else
  assign pick_data = data_req_i;
`endif

  assign ld_gnt_o    = ld_req_i;
  assign data_gnt_o  = core_en & pick_data;
  assign instr_gnt_o = core_en & instr_req_i & ~pick_data;

  logic [31:0] sel_addr;
  logic        sel_we;
  logic [3:0]  sel_be;
  logic [31:0] sel_wdata;
  logic        any_gnt;
  logic        in_range;
  logic        unused_addr_bits;

  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_be    = 4'h0;
    sel_wdata = '0;
    unique case (1'b1)
      ld_gnt_o: begin
        sel_addr  = ld_addr_i;
        sel_we    = 1'b1;
        sel_be    = 4'hF;
        sel_wdata = ld_wdata_i;
      end
      data_gnt_o: begin
        sel_addr  = data_addr_i;
        sel_we    = data_we_i;
        sel_be    = data_be_i;
        sel_wdata = data_wdata_i;
      end
      instr_gnt_o: begin
        sel_addr  = instr_addr_i;
        sel_be    = 4'hF;
      end
      default: ;
    endcase
  end

  assign any_gnt  = ld_gnt_o | data_gnt_o | instr_gnt_o;
  assign in_range = (sel_addr[31:ADDR_W+2] == '0);
  assign unused_addr_bits = ^sel_addr[1:0];

  assign ram_req_o   = any_gnt & in_range;
  assign ram_we_o    = ram_req_o & sel_we;
  assign ram_be_o    = ram_req_o ? sel_be : 4'h0;
  assign ram_addr_o  = ram_req_o ? sel_addr[ADDR_W+1:2] : '0;
  assign ram_wdata_o = ram_req_o ? sel_wdata : '0;

  logic i_pend_q, i_ok_q;
  logic d_pend_q, d_ok_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      i_pend_q <= 1'b0;
      i_ok_q   <= 1'b0;
      d_pend_q <= 1'b0;
      d_ok_q   <= 1'b0;
    end else begin
      i_pend_q <= instr_gnt_o;
      i_ok_q   <= instr_gnt_o & in_range;
      d_pend_q <= data_gnt_o;
      d_ok_q   <= data_gnt_o & ~data_we_i & in_range;
    end
  end

  assign instr_rvalid_o = i_pend_q;
  assign instr_rdata_o  = i_ok_q ? ram_rdata_i : '0;
  assign data_rvalid_o  = d_pend_q;
  assign data_rdata_o   = d_ok_q ? ram_rdata_i : '0;

endmodule

// File: tb/tb_miriscv_ram_arbiter.sv
// Bench for miriscv_ram_arbiter: RAM model, cycle model, directed vectors.
// Build with or without ARB_RR_EN; expectations follow the macro.
module tb_miriscv_ram_arbiter;

  localparam int RAM_SIZE  = 512;
  localparam int BOOT_HOLD = 2;
  localparam int AW        = 9;

  logic        clk = 0;
  logic        rst = 1;
  logic        instr_req = 0;
  logic [31:0] instr_addr = 0;
  logic        instr_gnt, instr_rvalid;
  logic [31:0] instr_rdata;
  logic        data_req = 0, data_we = 0;
  logic [3:0]  data_be = 0;
  logic [31:0] data_addr = 0, data_wdata = 0;
  logic        data_gnt, data_rvalid;
  logic [31:0] data_rdata;
  logic        ld_req = 0;
  logic [31:0] ld_addr = 0, ld_wdata = 0;
  logic        ld_gnt;
  logic        ld_done = 0;
  logic        core_rst_n;
  logic        ram_req, ram_we;
  logic [3:0]  ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  miriscv_ram_arbiter #(.RAM_SIZE(RAM_SIZE), .BOOT_HOLD(BOOT_HOLD)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr),
    .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid),
    .instr_rdata_o(instr_rdata),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_rdata_o(data_rdata),
    .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata),
    .ld_gnt_o(ld_gnt), .ld_done_i(ld_done),
    .core_rst_n_o(core_rst_n),
    .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit inr(logic [31:0] a);
    return a[31:AW+2] == '0;
  endfunction

  // Single-port RAM, 1-cycle read latency; junk when no read
  logic [31:0] ram [RAM_SIZE];

  always @(posedge clk) begin
    if (ram_req && !ram_we) ram_rdata <= ram[ram_addr];
    else ram_rdata <= 32'hBAD0BAD0;
    if (ram_req && ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
  end

  logic [31:0] mm [RAM_SIZE];
  int          cyc = 0;
  int          done_cyc = -1;
  bit          last_d = 1;
  bit          e_irv = 0, e_drv = 0, n_irv = 0, n_drv = 0;
  logic [31:0] e_ird = 0, e_drd = 0, n_ird = 0, n_drd = 0;

  always @(negedge clk) begin : model
    bit run, gl, gi, gd, core, rq;
    logic [31:0] a;
    int idx;
    if (rst) begin
      cyc = 0; done_cyc = -1; last_d = 1;
      e_irv = 0; e_drv = 0; e_ird = 0; e_drd = 0;
    end
    run  = (done_cyc >= 0) && (cyc >= done_cyc + BOOT_HOLD + 1);
    gl   = ld_req;
    core = run && !ld_req;
    gd = 0; gi = 0;
    if (core && instr_req && data_req) begin
`ifdef ARB_RR_EN
      gd = !last_d;
`else
      gd = 1;
`endif
      gi = !gd;
    end else begin
      gd = core && data_req;
      gi = core && instr_req;
    end
    a  = gl ? ld_addr : (gd ? data_addr : instr_addr);
    rq = (gl || gi || gd) && inr(a);
    idx = int'(a[AW+1:2]);
    chk("ld_gnt", 32'(ld_gnt), 32'(gl));
    chk("instr_gnt", 32'(instr_gnt), 32'(gi));
    chk("data_gnt", 32'(data_gnt), 32'(gd));
    chk("core_rst_n", 32'(core_rst_n), 32'(run));
    chk("instr_rvalid", 32'(instr_rvalid), 32'(e_irv));
    chk("instr_rdata", instr_rdata, e_ird);
    chk("data_rvalid", 32'(data_rvalid), 32'(e_drv));
    chk("data_rdata", data_rdata, e_drd);
    chk("ram_req", 32'(ram_req), 32'(rq));
    if (rq) begin
      chk("ram_we", 32'(ram_we), 32'(gl || (gd && data_we)));
      chk("ram_addr", 32'(ram_addr), 32'(idx));
    end
    if (!rst) begin
      if (ld_done && done_cyc < 0) done_cyc = cyc;
      n_irv = gi;
      n_ird = (gi && rq) ? mm[idx] : 32'h0;
      n_drv = gd;
      n_drd = (gd && !data_we && rq) ? mm[idx] : 32'h0;
      if (rq && gl) mm[idx] = ld_wdata;
      if (rq && gd && data_we)
        for (int b = 0; b < 4; b++)
          if (data_be[b]) mm[idx][8*b +: 8] = data_wdata[8*b +: 8];
      if (gi) last_d = 0;
      else if (gd) last_d = 1;
    end else begin
      n_irv = 0; n_drv = 0; n_ird = 0; n_drd = 0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      e_irv = 0; e_drv = 0; e_ird = 0; e_drd = 0;
    end else begin
      e_irv = n_irv; e_ird = n_ird;
      e_drv = n_drv; e_drd = n_drd;
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [1:0] exp_g;
    for (int i = 0; i < RAM_SIZE; i++) begin
      ram[i] = 32'h1000_0000 + i;
      mm[i]  = 32'h1000_0000 + i;
    end
    ram[1] = 32'hDEADBEEF; mm[1] = 32'hDEADBEEF;
    ram[2] = 32'hFFFFFFFF; mm[2] = 32'hFFFFFFFF;

    @(negedge clk);
    chk("rst_core", 32'(core_rst_n), 32'h0);
    chk("rst_ram_req", 32'(ram_req), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    step();
    ld_req = 1; ld_addr = 0; ld_wdata = 32'h00C00093;
    instr_req = 1; data_req = 1;
    @(negedge clk);
    chk("boot_ld_gnt", 32'(ld_gnt), 32'h1);
    chk("boot_instr_gnt", 32'(instr_gnt), 32'h0);
    chk("boot_data_gnt", 32'(data_gnt), 32'h0);
    step();
    ld_req = 0; instr_req = 0; data_req = 0;
    @(negedge clk);
    chk("ld_mem0", ram[0], 32'h00C00093);

    step();
    ld_done = 1;
    step();
    ld_done = 0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (core_rst_n) break;
    end
    chk("boot_hold_cycles", 32'(n), 32'(BOOT_HOLD + 1));

    step();
    instr_req = 1; instr_addr = 32'h4;
    @(negedge clk);
    chk("if_gnt", 32'(instr_gnt), 32'h1);
    step();
    instr_req = 0;
    @(negedge clk);
    chk("if_rvalid", 32'(instr_rvalid), 32'h1);
    chk("if_rdata", instr_rdata, 32'hDEADBEEF);

    step();
    data_req = 1; data_we = 1; data_be = 4'b0011;
    data_addr = 32'h8; data_wdata = 32'h12345678;
    @(negedge clk);
    chk("wr_gnt", 32'(data_gnt), 32'h1);
    step();
    data_we = 0; data_be = 4'hF;
    @(negedge clk);
    chk("wr_rvalid", 32'(data_rvalid), 32'h1);
    chk("wr_rdata", data_rdata, 32'h0);
    step();
    data_req = 0;
    @(negedge clk);
    chk("rb_rdata", data_rdata, 32'hFFFF5678);

    step();
    instr_req = 1; instr_addr = 32'h0;
    data_req = 1; data_addr = 32'hC;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
`ifdef ARB_RR_EN
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp_g = 2'b01;
`endif
      chk("arb_seq", 32'({instr_gnt, data_gnt}), 32'(exp_g));
      step();
    end
    instr_req = 0; data_req = 0;

    step();
    ld_req = 1; ld_addr = 32'h10; ld_wdata = 32'hA5A5A5A5;
    data_req = 1; data_addr = 32'h10;
    @(negedge clk);
    chk("ld_vs_d_ld", 32'(ld_gnt), 32'h1);
    chk("ld_vs_d_d", 32'(data_gnt), 32'h0);
    step();
    ld_req = 0;
    @(negedge clk);
    chk("d_after_ld", 32'(data_gnt), 32'h1);
    step();
    data_req = 0;
    @(negedge clk);
    chk("d_after_ld_rdata", data_rdata, 32'hA5A5A5A5);

    step();
    instr_req = 1; instr_addr = 32'h800;
    @(negedge clk);
    chk("oor_gnt", 32'(instr_gnt), 32'h1);
    chk("oor_ram_req", 32'(ram_req), 32'h0);
    step();
    instr_req = 0;
    @(negedge clk);
    chk("oor_rvalid", 32'(instr_rvalid), 32'h1);
    chk("oor_rdata", instr_rdata, 32'h0);

    step();
    data_req = 1; data_addr = 32'h4;
    @(negedge clk);
    chk("pend_gnt", 32'(data_gnt), 32'h1);
    step();
    data_req = 0;
    rst = 1;
    #1;
    chk("rst_drop_rvalid", 32'(data_rvalid), 32'h0);
    chk("rst_core_now", 32'(core_rst_n), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
